// File: rtl/ir_timing.sv
// Instruction register and T-state timing generator for the 6502 core.
// Latches the opcode at the end of T1 and sequences T0..T5/TX with active-low decoded lines.
module ir_timing #(
  parameter logic [7:0] RESET_IR   = 8'h00,
  parameter logic [7:0] BRK_OPCODE = 8'h00
) (
  input  logic       CLK,
  input  logic       n_RES,
  input  logic       RDY,
  input  logic [7:0] DB,
  input  logic       TRES,
  input  logic       INT_PEND,
  output logic       n_T0,
  output logic       n_T1X,
  output logic       n_T2,
  output logic       n_T3,
  output logic       n_T4,
  output logic       n_T5,
  output logic       SYNC,
  output logic [7:0] IR,
  output logic [7:0] n_IR,
  output logic       IR01
);

  typedef enum logic [2:0] {
    S_T0 = 3'd0,
    S_T1 = 3'd1,
    S_T2 = 3'd2,
    S_T3 = 3'd3,
    S_T4 = 3'd4,
    S_T5 = 3'd5,
    S_TX = 3'd6
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [5:0] lines;       // {n_T5..n_T0}, active low
  logic [5:0] lines_next;
  logic       sync_next;

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state <= S_T2;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (RDY) begin
      case (state)
        S_T0:    state_next = S_T1;
        S_T1:    state_next = S_T2;
        S_T2:    state_next = TRES ? S_T0 : S_T3;
        S_T3:    state_next = TRES ? S_T0 : S_T4;
        S_T4:    state_next = TRES ? S_T0 : S_T5;
        S_T5:    state_next = TRES ? S_T0 : S_TX;
        S_TX:    state_next = TRES ? S_T0 : S_TX;
        default: state_next = S_T2;
      endcase
    end
  end

  // T lines are decoded from the next state and registered so the PLA sees glitch-free strobes.
  always_comb begin
    lines_next = '1;
    sync_next  = 1'b0;
    case (state_next)
      S_T0:    lines_next[0] = 1'b0;
      S_T1: begin
        lines_next[1] = 1'b0;
        sync_next     = 1'b1;
      end
      S_T2:    lines_next[2] = 1'b0;
      S_T3:    lines_next[3] = 1'b0;
      S_T4:    lines_next[4] = 1'b0;
      S_T5:    lines_next[5] = 1'b0;
      default: lines_next = '1;
    endcase
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      lines <= 6'b111011;
      SYNC  <= 1'b0;
    end else begin
      lines <= lines_next;
      SYNC  <= sync_next;
    end
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      IR <= RESET_IR;
    end else if (RDY && state == S_T1) begin
      IR <= INT_PEND ? BRK_OPCODE : DB;
    end
  end

  assign n_T0  = lines[0];
  assign n_T1X = lines[1];
  assign n_T2  = lines[2];
  assign n_T3  = lines[3];
  assign n_T4  = lines[4];
  assign n_T5  = lines[5];
  assign n_IR  = ~IR;
  assign IR01  = IR[0] | IR[1];

endmodule
